// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared op-class constants, FSM encoding and field bundle for the instruction encoder.
package instr_encoder_pkg;
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_ILL = 2'b11;
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ENCODE = 2'b01;
    localparam logic [1:0] S_WRITE  = 2'b10;
    localparam logic [1:0] S_DONE   = 2'b11;
    localparam int MAX_WORDS = 64;
    typedef struct packed {
        logic [3:0]  cond;
        logic [1:0]  op;
        logic [5:0]  funct;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } fields_t;
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-transfer handshake between an instruction source and the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        finish;
    logic [3:0]  Cond;
    logic [1:0]  Op;
    logic [5:0]  Funct;
    logic [3:0]  Rn;
    logic [3:0]  Rd;
    logic [11:0] Src2;
    logic [23:0] Imm24;
    modport master(output in_valid, finish, Cond, Op, Funct, Rn, Rd, Src2, Imm24, input in_ready);
    modport slave(input in_valid, finish, Cond, Op, Funct, Rn, Rd, Src2, Imm24, output in_ready);
endinterface

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational formation of the 32-bit machine word from fields, flagging the illegal op class.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fields_t     f,
    output logic [31:0] word,
    output logic        illegal
);
    assign word = f.op == OP_BR ? {f.cond, OP_BR, f.funct[5:4], f.imm24}
                                : {f.cond, f.op, f.funct, f.rn, f.rd, f.src2};
    assign illegal = f.op == OP_ILL;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction fields, encodes them and writes one word per slot into instruction memory,
// holding the CPU in reset until the program is closed.
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    instr_encoder_if.slave  bus,
    output logic            MemW,
    output logic [31:0]     Adr,
    output logic [31:0]     WriteData,
    output logic [6:0]      count,
    output logic            full,
    output logic            err,
    output logic            done,
    output logic            cpu_hold
);
    logic [1:0]  state;
    fields_t     f;
    logic [31:0] packed_word;
    logic [31:0] word;
    logic        illegal;
    logic        xfer;

    instr_pack u_pack (.f(f), .word(packed_word), .illegal(illegal));

    assign full         = count == 7'(MAX_WORDS);
    assign bus.in_ready = state == S_IDLE && !full;
    assign xfer         = bus.in_valid && bus.in_ready;
    assign MemW         = state == S_WRITE;
    assign done         = state == S_DONE;
    assign cpu_hold     = !done;
    assign Adr          = {23'b0, count, 2'b00};
    assign WriteData    = word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            f     <= '0;
            word  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // a transfer takes priority over a coincident finish
                    if (xfer) begin
                        f     <= {bus.Cond, bus.Op, bus.Funct, bus.Rn, bus.Rd, bus.Src2, bus.Imm24};
                        state <= S_ENCODE;
                    end else if (bus.finish && count != 7'd0) begin
                        state <= S_DONE;
                    end
                end
                S_ENCODE: begin
                    word  <= packed_word;
                    err   <= err | illegal;
                    state <= illegal ? S_IDLE : S_WRITE;
                end
                S_WRITE: begin
                    if (!full) count <= count + 7'd1;
                    state <= S_IDLE;
                end
                default: state <= S_DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: randomized scoreboard bench; a driver queues expected memory writes, a monitor checks each MemW.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemW;
    logic [31:0] Adr, WriteData;
    logic [6:0]  count;
    logic        full, err, done, cpu_hold;

    always #5 clk = ~clk;

    instr_encoder_if bus();

    instr_encoder dut (
        .clk(clk), .reset(reset), .bus(bus),
        .MemW(MemW), .Adr(Adr), .WriteData(WriteData), .count(count),
        .full(full), .err(err), .done(done), .cpu_hold(cpu_hold)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoding straight from the field layout, using shifts and ORs
    function automatic logic [31:0] ref_word(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                                             input logic [3:0] rn, input logic [3:0] rd,
                                             input logic [11:0] s2, input logic [23:0] im);
        if (o == 2'd2)
            return (32'(c) << 28) | (32'd2 << 26) | (32'(fn >> 4) << 24) | 32'(im);
        return (32'(c) << 28) | (32'(o) << 26) | (32'(fn) << 20) | (32'(rn) << 16) | (32'(rd) << 12) | 32'(s2);
    endfunction

    always @(negedge clk) begin
        if (reset && MemW) begin
            if (q.size() == 0) begin
                chk("unexpected_memw", 32'(MemW), 32'd0);
            end else begin
                mon_e = q.pop_front();
                chk("adr", Adr, mon_e.adr);
                chk("writedata", WriteData, mon_e.data);
                chk("latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic send(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn, input logic [3:0] rn,
                        input logic [3:0] rd, input logic [11:0] s2, input logic [23:0] im,
                        input logic fin, input logic [31:0] expw);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.finish = fin;
        bus.Cond = c; bus.Op = o; bus.Funct = fn; bus.Rn = rn; bus.Rd = rd; bus.Src2 = s2; bus.Imm24 = im;
        if (o != 2'b11) begin
            q.push_back('{adr: 32'(model_count) * 4, data: expw, cyc: cyc + 2});
            model_count++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.finish = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    task automatic send_rand(input logic fin);
        logic [3:0] c, rn, rd;
        logic [1:0] o;
        logic [5:0] fn;
        logic [11:0] s2;
        logic [23:0] im;
        c = 4'($urandom); o = 2'($urandom); fn = 6'($urandom); rn = 4'($urandom);
        rd = 4'($urandom); s2 = 12'($urandom); im = 24'($urandom);
        send(c, o, fn, rn, rd, s2, im, fin, ref_word(c, o, fn, rn, rd, s2, im));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid = 1'b0; bus.finish = 1'b0;
        bus.Cond = '0; bus.Op = '0; bus.Funct = '0; bus.Rn = '0; bus.Rd = '0; bus.Src2 = '0; bus.Imm24 = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_memw", 32'(MemW), 32'd0);
        chk("rst_adr", Adr, 32'd0);
        chk("rst_writedata", WriteData, 32'd0);
        chk("rst_full", 32'(full), 32'd0);

        send(4'hE, 2'b00, 6'b101000, 4'd2, 4'd1, 12'h005, 24'h0, 1'b0, 32'hE2821005);
        send(4'hE, 2'b01, 6'b011001, 4'd4, 4'd3, 12'h008, 24'h0, 1'b0, 32'hE5943008);
        send(4'hE, 2'b10, 6'b100110, 4'hF, 4'hA, 12'hABC, 24'h000002, 1'b0, 32'hEA000002);
        drain();
        repeat (2) @(negedge clk);
        chk("count_after_directed", 32'(count), 32'd3);
        chk("err_clean", 32'(err), 32'd0);

        send(4'hE, 2'b11, 6'h15, 4'd1, 4'd2, 12'h123, 24'h0, 1'b0, 32'h0);
        repeat (4) @(negedge clk);
        chk("err_set", 32'(err), 32'd1);
        chk("count_after_illegal", 32'(count), 32'd3);

        while (model_count < MAX_WORDS) send_rand(1'b0);
        drain();
        repeat (2) @(negedge clk);
        chk("count_full", 32'(count), 32'd64);
        chk("full", 32'(full), 32'd1);
        chk("in_ready_full", 32'(bus.in_ready), 32'd0);
        chk("err_sticky", 32'(err), 32'd1);

        bus.in_valid = 1'b1;
        repeat (6) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("count_saturated", 32'(count), 32'd64);

        bus.finish = 1'b1;
        @(negedge clk);
        bus.finish = 1'b0;
        chk("done_after_finish", 32'(done), 32'd1);
        chk("cpu_hold_released", 32'(cpu_hold), 32'd0);
        chk("in_ready_done", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("done_terminal", 32'(done), 32'd1);
        chk("count_in_done", 32'(count), 32'd64);

        reset = 1'b0;
        #1;
        chk("async_reset_count", 32'(count), 32'd0);
        chk("async_reset_hold", 32'(cpu_hold), 32'd1);
        model_count = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("err_cleared", 32'(err), 32'd0);

        bus.finish = 1'b1;
        @(negedge clk);
        bus.finish = 1'b0;
        @(negedge clk);
        chk("finish_empty_ignored", 32'(done), 32'd0);

        send_rand(1'b1);
        while (model_count == 0) send_rand(1'b1);
        drain();
        repeat (2) @(negedge clk);
        chk("finish_dropped", 32'(done), 32'd0);
        chk("idle_after_race", 32'(bus.in_ready), 32'd1);
        chk("count_after_race", 32'(count), 32'(model_count));

        send(4'h1, 2'b00, 6'h3F, 4'd5, 4'd6, 12'hFFF, 24'h0, 1'b0, ref_word(4'h1, 2'b00, 6'h3F, 4'd5, 4'd6, 12'hFFF, 24'h0));
        n = 0;
        while (!MemW && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("memw_seen", 32'(MemW), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("memw_abort", 32'(MemW), 32'd0);
        chk("count_abort", 32'(count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("count_not_incremented", 32'(count), 32'd0);
        chk("queue_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
